// File: rtl/inst_fetch_buffer.sv
// ---------------------------------------------------------------------------
// inst_fetch_buffer
//
// Instruction fetch stage that sits directly in front of the CPU. It follows
// the CPU program counter and prefetches sequential words from a
// variable-latency instruction memory into a small address+data queue. It
// presents the word that matches pc together with a valid flag; the CPU clock
// enable is gated externally by inst_valid. Any pc that differs from the
// expected sequential address counts as a redirect. A redirect flushes the
// queue and restarts fetching at pc.
//
// Parameters
//   DEPTH_LOG2  queue depth = 2**DEPTH_LOG2 entries
//   RESET_PC    first fetch address after reset
//
// Ports
//   clk_cpu            in   clock, rising edge
//   reset              in   synchronous, active-high
//   pc[31:0]           in   current CPU program counter
//   inst_ack           in   CPU consumed the presented instruction
//   inst[31:0]         out  instruction for pc, 0 (NOP) when !inst_valid
//   inst_valid         out  inst is valid for the current pc
//   mem_req            out  memory read request (registered)
//   mem_adrs[31:0]     out  memory read address, stable while mem_req
//   mem_ack            in   one-cycle acknowledge, honoured only while mem_req
//   mem_rd_data[31:0]  in   read data, valid with mem_ack
//
// Optional build macro FETCH_STATS_EN adds the following outputs:
//   stat_redirects[15:0]     cycles with a redirect (saturating)
//   stat_stall_cycles[15:0]  cycles with inst_valid=0 (saturating)
// ---------------------------------------------------------------------------
module inst_fetch_buffer #(
  parameter int          DEPTH_LOG2 = 2,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk_cpu,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        inst_ack,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        mem_req,
  output logic [31:0] mem_adrs,
  input  logic        mem_ack,
  input  logic [31:0] mem_rd_data
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0] stat_redirects,
  output logic [15:0] stat_stall_cycles
`endif
);

  localparam int                  DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL  = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t                state, state_next;
  logic [31:0]           q_adrs [DEPTH];
  logic [31:0]           q_data [DEPTH];
  logic [DEPTH_LOG2-1:0] head, tail;
  logic [DEPTH_LOG2:0]   count;
  logic [31:0]           fetch_adrs;
  logic [31:0]           exp_adrs;
  logic                  redirect;
  logic                  issue, retire, push, pop;

  // The address the CPU should present next if nothing has redirected it:
  // the oldest buffered word first, then the word in flight, then the next
  // address to fetch. A DISCARD request never counts, because its data is
  // thrown away.
  always_comb begin
    exp_adrs = fetch_adrs;
    if (count != '0)
      exp_adrs = q_adrs[head];
    else if (state == WAIT)
      exp_adrs = mem_adrs;
  end

  assign redirect   = (exp_adrs != pc);
  assign inst_valid = (count != '0) && (q_adrs[head] == pc);
  assign inst       = inst_valid ? q_data[head] : 32'h0;
  // A valid head always equals pc, so a pop can never coincide with a redirect.
  assign pop        = inst_ack && inst_valid;

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    retire     = 1'b0;
    push       = 1'b0;
    case (state)
      IDLE: begin
        if (!redirect && (count < FULL)) begin
          issue      = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (mem_ack) begin
          retire     = 1'b1;
          push       = !redirect;
          state_next = IDLE;
        end else if (redirect) begin
          state_next = DISCARD;
        end
      end
      DISCARD: begin
        if (mem_ack) begin
          retire     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_adrs   <= 32'h0;
      fetch_adrs <= RESET_PC;
      count      <= '0;
      head       <= '0;
      tail       <= '0;
    end else begin
      state <= state_next;
      if (issue) begin
        mem_req  <= 1'b1;
        mem_adrs <= fetch_adrs;
      end else if (retire) begin
        mem_req  <= 1'b0;
      end
      if (redirect) begin
        count      <= '0;
        head       <= '0;
        tail       <= '0;
        fetch_adrs <= pc;
      end else begin
        if (push) begin
          tail       <= tail + 1'b1;
          fetch_adrs <= mem_adrs + 32'd4;
        end
        if (pop)
          head <= head + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Queue storage is not reset: occupancy is tracked entirely by count.
  always_ff @(posedge clk_cpu) begin
    if (push) begin
      q_adrs[tail] <= mem_adrs;
      q_data[tail] <= mem_rd_data;
    end
  end

`ifdef FETCH_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      stat_redirects    <= 16'h0;
      stat_stall_cycles <= 16'h0;
    end else begin
      if (redirect)
        stat_redirects <= sat_inc(stat_redirects);
      if (!inst_valid)
        stat_stall_cycles <= sat_inc(stat_stall_cycles);
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_buffer.sv
module tb_inst_fetch_buffer;
  localparam int          DEPTH_LOG2 = 2;
  localparam int          DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;

  logic        clk_cpu = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = 32'h0;
  logic        inst_ack = 1'b0;
  logic [31:0] inst;
  logic        inst_valid;
  logic        mem_req;
  logic [31:0] mem_adrs;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rd_data = 32'h0;
`ifdef FETCH_STATS_EN
  logic [15:0] stat_redirects, stat_stall_cycles;
`endif

  always #5 clk_cpu = ~clk_cpu;

  inst_fetch_buffer #(.DEPTH_LOG2(DEPTH_LOG2), .RESET_PC(RESET_PC)) dut (
    .clk_cpu(clk_cpu), .reset(reset), .pc(pc), .inst_ack(inst_ack),
    .inst(inst), .inst_valid(inst_valid), .mem_req(mem_req),
    .mem_adrs(mem_adrs), .mem_ack(mem_ack), .mem_rd_data(mem_rd_data)
`ifdef FETCH_STATS_EN
    , .stat_redirects(stat_redirects), .stat_stall_cycles(stat_stall_cycles)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the buffer is a list of fetched {address, word} pairs,
  // plus at most one outstanding memory read that may have been cancelled.
  logic [31:0] m_qa[$];
  logic [31:0] m_qd[$];
  bit          out_pend = 0;
  bit          out_drop = 0;
  logic [31:0] m_adrs  = 32'h0;
  logic [31:0] m_fetch = RESET_PC;

  int          ack_delay = 1;
  int          req_age   = 0;
  bit          auto_pc   = 0;
  bit          prev_req  = 0;
  logic [31:0] issued[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit m_valid();
    return (m_qa.size() > 0) && (m_qa[0] == pc);
  endfunction

  function automatic logic [31:0] m_inst();
    return m_valid() ? m_qd[0] : 32'h0;
  endfunction

  task automatic model_update();
    int          sz;
    logic [31:0] expect_pc;
    bit          v;
    if (reset) begin
      m_qa.delete(); m_qd.delete();
      out_pend = 0; out_drop = 0; m_adrs = 32'h0; m_fetch = RESET_PC;
      return;
    end
    sz = m_qa.size();
    if (sz > 0)                   expect_pc = m_qa[0];
    else if (out_pend && !out_drop) expect_pc = m_adrs;
    else                          expect_pc = m_fetch;
    if (expect_pc != pc) begin
      m_qa.delete(); m_qd.delete();
      m_fetch = pc;
      if (out_pend) begin
        if (mem_ack) begin out_pend = 0; out_drop = 0; end
        else out_drop = 1;
      end
    end else begin
      v = m_valid();
      if (out_pend) begin
        if (mem_ack) begin
          if (!out_drop) begin
            m_qa.push_back(m_adrs); m_qd.push_back(mem_rd_data);
            m_fetch = m_adrs + 32'd4;
          end
          out_pend = 0; out_drop = 0;
        end
      end else if (sz < DEPTH) begin
        out_pend = 1; out_drop = 0; m_adrs = m_fetch;
      end
      if (v && inst_ack) begin
        void'(m_qa.pop_front()); void'(m_qd.pop_front());
      end
    end
  endtask

  // Memory responder: acks ack_delay cycles into each request.
  task automatic drive_mem();
    if (mem_req) begin
      req_age++;
      mem_ack = (req_age >= ack_delay);
      mem_rd_data = mem_ack ? mem_word(mem_adrs) : $urandom;
    end else begin
      req_age = 0;
      mem_ack = 1'b0;
      mem_rd_data = $urandom;
    end
  endtask

  task automatic advance();
    bit v;
    v = m_valid();
    @(posedge clk_cpu);
    model_update();
    @(negedge clk_cpu);
    if (auto_pc && inst_ack && v && !reset) pc = pc + 32'd4;
    if (mem_req && !prev_req) issued.push_back(mem_adrs);
    prev_req = mem_req;
    drive_mem();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; auto_pc = 0; inst_ack = 1'b0; pc = 32'h0;
    advance(); advance();
    reset = 1'b0;
    issued.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; pc = 32'h0; inst_ack = 1'b1;
    advance(); advance();
    n_checks += 4;
    if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", inst_valid); end
    if (inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst got %h want 0", inst); end
    if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", mem_req); end
    if (mem_adrs !== 32'h0) begin n_fail++; $display("FAIL reset_adrs got %h want 0", mem_adrs); end
    reset = 1'b0; inst_ack = 1'b0;
  endtask

  task automatic test_sequential();
    do_reset();
    ack_delay = 1; pc = 32'h0; inst_ack = 1'b1; auto_pc = 1;
    for (int i = 0; i < 30; i++) begin
      advance();
      n_checks += 4;
      if (inst_valid !== m_valid()) begin n_fail++; $display("FAIL seq_valid cyc %0d got %b want %b", i, inst_valid, m_valid()); end
      if (inst !== m_inst()) begin n_fail++; $display("FAIL seq_inst cyc %0d got %h want %h", i, inst, m_inst()); end
      if (mem_req !== out_pend) begin n_fail++; $display("FAIL seq_req cyc %0d got %b want %b", i, mem_req, out_pend); end
      if (mem_adrs !== m_adrs) begin n_fail++; $display("FAIL seq_adrs cyc %0d got %h want %h", i, mem_adrs, m_adrs); end
    end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (issued.size() <= k) begin n_fail++; $display("FAIL seq_order idx %0d got none want %h", k, k * 4); end
      else if (issued[k] !== 32'(k * 4)) begin n_fail++; $display("FAIL seq_order idx %0d got %h want %h", k, issued[k], k * 4); end
    end
    auto_pc = 0; inst_ack = 1'b0;
  endtask

  task automatic test_fill();
    do_reset();
    ack_delay = 1; pc = 32'h0; inst_ack = 1'b0;
    for (int i = 0; i < 30; i++) advance();
    n_checks++;
    if (issued.size() != 4) begin n_fail++; $display("FAIL fill_count got %0d want 4", issued.size()); end
    for (int k = 0; k < 4 && k < issued.size(); k++) begin
      n_checks++;
      if (issued[k] !== 32'(k * 4)) begin n_fail++; $display("FAIL fill_adrs idx %0d got %h want %h", k, issued[k], k * 4); end
    end
    n_checks += 3;
    if (mem_req !== 1'b0) begin n_fail++; $display("FAIL fill_req got %b want 0", mem_req); end
    if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL fill_valid got %b want 1", inst_valid); end
    if (inst !== mem_word(32'h0)) begin n_fail++; $display("FAIL fill_inst got %h want %h", inst, mem_word(32'h0)); end
  endtask

  task automatic test_redirect_flush();
    bit seen;
    pc = 32'h100; #1;
    n_checks += 2;
    if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b want 0", inst_valid); end
    if (inst !== 32'h0) begin n_fail++; $display("FAIL flush_inst got %h want 0", inst); end
    issued.delete();
    for (int i = 0; i < 20 && issued.size() == 0; i++) advance();
    n_checks++;
    if (issued.size() == 0) begin n_fail++; $display("FAIL flush_req got none want 00000100"); end
    else if (issued[0] !== 32'h100) begin n_fail++; $display("FAIL flush_req got %h want 00000100", issued[0]); end
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      advance();
      seen = inst_valid;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL flush_refill got no valid want valid"); end
    else if (inst !== mem_word(32'h100)) begin n_fail++; $display("FAIL flush_refill got %h want %h", inst, mem_word(32'h100)); end
  endtask

  task automatic test_discard();
    do_reset();
    ack_delay = 5; pc = 32'h0; inst_ack = 1'b0;
    for (int i = 0; i < 10 && !mem_req; i++) advance();
    advance(); advance();
    pc = 32'h40;
    for (int i = 0; i < 25; i++) begin
      if (i > 0) advance(); else #1;
      n_checks += 4;
      if (inst_valid !== m_valid()) begin n_fail++; $display("FAIL disc_valid cyc %0d got %b want %b", i, inst_valid, m_valid()); end
      if (inst !== m_inst()) begin n_fail++; $display("FAIL disc_inst cyc %0d got %h want %h", i, inst, m_inst()); end
      if (mem_req !== out_pend) begin n_fail++; $display("FAIL disc_req cyc %0d got %b want %b", i, mem_req, out_pend); end
      if (mem_adrs !== m_adrs) begin n_fail++; $display("FAIL disc_adrs cyc %0d got %h want %h", i, mem_adrs, m_adrs); end
    end
    n_checks += 2;
    if (issued.size() < 2) begin n_fail++; $display("FAIL disc_next got %0d requests want >=2", issued.size()); end
    else begin
      if (issued[0] !== 32'h0) begin n_fail++; $display("FAIL disc_first got %h want 0", issued[0]); end
      if (issued[1] !== 32'h40) begin n_fail++; $display("FAIL disc_next got %h want 00000040", issued[1]); end
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    ack_delay = 5; pc = 32'h0; inst_ack = 1'b0;
    for (int i = 0; i < 10 && !mem_req; i++) advance();
    reset = 1'b1;
    advance();
    n_checks += 2;
    if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rstwait_req got %b want 0", mem_req); end
    if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rstwait_valid got %b want 0", inst_valid); end
    reset = 1'b0;
    mem_ack = 1'b1; mem_rd_data = 32'hDEAD_BEEF;
    issued.delete();
    advance();
    n_checks += 2;
    if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rstwait_restart got %b want 1", mem_req); end
    if (mem_adrs !== RESET_PC) begin n_fail++; $display("FAIL rstwait_pc got %h want %h", mem_adrs, RESET_PC); end
    for (int i = 0; i < 15; i++) begin
      advance();
      n_checks += 2;
      if (inst_valid !== m_valid()) begin n_fail++; $display("FAIL rstwait_valid2 cyc %0d got %b want %b", i, inst_valid, m_valid()); end
      if (inst !== m_inst()) begin n_fail++; $display("FAIL rstwait_inst cyc %0d got %h want %h", i, inst, m_inst()); end
    end
  endtask

  task automatic test_wrap();
    bit seen0;
    do_reset();
    ack_delay = 1; pc = 32'hFFFF_FFFC; inst_ack = 1'b1; auto_pc = 1;
    seen0 = 0;
    for (int i = 0; i < 25; i++) begin
      advance();
      if (inst_valid && pc == 32'h0) seen0 = 1;
      n_checks += 3;
      if (inst_valid !== m_valid()) begin n_fail++; $display("FAIL wrap_valid cyc %0d got %b want %b", i, inst_valid, m_valid()); end
      if (inst !== m_inst()) begin n_fail++; $display("FAIL wrap_inst cyc %0d got %h want %h", i, inst, m_inst()); end
      if (mem_adrs !== m_adrs) begin n_fail++; $display("FAIL wrap_adrs cyc %0d got %h want %h", i, mem_adrs, m_adrs); end
    end
    n_checks += 3;
    if (issued.size() < 2) begin n_fail++; $display("FAIL wrap_seq got %0d requests want >=2", issued.size()); end
    else begin
      if (issued[0] !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_first got %h want fffffffc", issued[0]); end
      if (issued[1] !== 32'h0) begin n_fail++; $display("FAIL wrap_next got %h want 00000000", issued[1]); end
    end
    if (!seen0) begin n_fail++; $display("FAIL wrap_pc0 got no valid at pc 0 want valid"); end
    auto_pc = 0; inst_ack = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    auto_pc = 1;
    for (int i = 0; i < 400; i++) begin
      advance();
      inst_ack = 1'($urandom);
      if (!mem_req) ack_delay = $urandom_range(1, 4);
      reset = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 3))
          0: pc = 32'h0;
          1: pc = 32'h40;
          2: pc = pc + 32'd8;
          default: pc = $urandom & 32'hFFFF_FFFC;
        endcase
      end
      #1;
      n_checks += 4;
      if (inst_valid !== m_valid()) begin n_fail++; $display("FAIL rnd_valid cyc %0d got %b want %b", i, inst_valid, m_valid()); end
      if (inst !== m_inst()) begin n_fail++; $display("FAIL rnd_inst cyc %0d got %h want %h", i, inst, m_inst()); end
      if (mem_req !== out_pend) begin n_fail++; $display("FAIL rnd_req cyc %0d got %b want %b", i, mem_req, out_pend); end
      if (mem_adrs !== m_adrs) begin n_fail++; $display("FAIL rnd_adrs cyc %0d got %h want %h", i, mem_adrs, m_adrs); end
    end
    reset = 1'b0; auto_pc = 0; inst_ack = 1'b0;
  endtask

  initial begin
    @(negedge clk_cpu);
    test_reset();
    test_sequential();
    test_fill();
    test_redirect_flush();
    test_discard();
    test_reset_mid_wait();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/inst_fetch_buffer.md
Name: inst_fetch_buffer

Overview:
Instruction fetch stage directly upstream of the CPU. Watches the CPU's pc and prefetches sequential words from a variable-latency instruction memory over a req/ack interface into a small queue. Presents the instruction matching pc together with a valid flag; the CPU clock enable is gated externally by inst_valid. A pc that differs from the expected sequential address is a redirect: the queue is flushed and fetching restarts at pc.

Parameters:
DEPTH_LOG2, 2, queue depth = 2**DEPTH_LOG2 entries (address + data per entry)
RESET_PC, 32'h00000000, first fetch address after reset

Ports:
clk_cpu  input  1  clock, rising edge
reset  input  1  synchronous, active-high
pc  input  32  current CPU program counter
inst_ack  input  1  CPU consumed the presented instruction this cycle
inst  output  32  instruction for pc; 32'h0 (NOP) when !inst_valid
inst_valid  output  1  inst is valid for the current pc
mem_req  output  1  memory read request, registered
mem_adrs  output  32  memory read address, registered, stable while mem_req
mem_ack  input  1  one-cycle acknowledge, counted only while mem_req=1
mem_rd_data  input  32  read data, valid with mem_ack

Behaviour:
- Reset: count=0, state=IDLE, mem_req=0, mem_adrs=0, fetch_adrs=RESET_PC; inst=0, inst_valid=0. Reset during WAIT aborts the request: mem_req drops next cycle; a stray ack arriving afterwards is ignored because mem_req=0.
- exp_adrs = head.adrs if count>0; else mem_adrs in WAIT; else fetch_adrs.
- redirect = (exp_adrs != pc); full 32-bit compare, no alignment masking.
- inst_valid = (count>0) && (head.adrs==pc), combinational from registered state. inst = head.data when valid, else 0.
- Pop: inst_ack && inst_valid removes head at the edge. inst_ack while !inst_valid is ignored.
- States:
  IDLE: if !redirect && count<DEPTH: mem_req<=1, mem_adrs<=fetch_adrs, go to WAIT. On redirect, no request is issued that cycle.
  WAIT: mem_req held, mem_adrs stable. On mem_ack: push {mem_adrs, mem_rd_data}, fetch_adrs<=mem_adrs+4 (mod 2**32), mem_req<=0, go to IDLE.
  DISCARD: mem_req held. On mem_ack: data dropped, mem_req<=0, go to IDLE.
- Redirect, any state: count<=0, fetch_adrs<=pc. WAIT goes to DISCARD. Redirect takes priority over push and pop in the same cycle. In WAIT, a redirect plus mem_ack in the same cycle drops the data and goes directly to IDLE.
- Only one request outstanding at a time. A request is issued only from IDLE with count<DEPTH, so the queue cannot overflow. Push and pop in the same cycle leave count unchanged.
- Latency: an ack at edge N makes the instruction visible from cycle N+1; no bypass path from mem_rd_data to inst.
- Minimum turnaround is one IDLE cycle between consecutive requests.

Optional Feature:
Macro FETCH_STATS_EN.
- Defined: adds outputs stat_redirects[15:0] (increments on each cycle redirect=1) and stat_stall_cycles[15:0] (increments on each cycle inst_valid=0). Both saturate at 16'hFFFF and clear on reset.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, memory acks 1 cycle after req, pc=0 with inst_ack=inst_valid -> mem_adrs 0,4,8 issued in order; inst equals mem[0], mem[4], mem[8] as pc steps 0,4,8.
- DEPTH_LOG2=2, inst_ack=0, pc held at 0 -> exactly 4 requests (0,4,8,12), then mem_req stays 0; inst_valid=1 with inst=mem[0].
- Queue holds 0..12, pc jumps to 0x100 -> inst_valid=0 that cycle; next mem_adrs=0x100; inst=mem[0x100] afterwards, no stale entries.
- Ack delay 5 cycles, pc changes to 0x40 mid-WAIT -> mem_req stays high until ack; that data is dropped; next request mem_adrs=0x40.
- Reset asserted while mem_req=1 -> mem_req=0, inst_valid=0 next cycle; first request after release uses RESET_PC.
- pc=0xFFFFFFFC, inst_ack each valid cycle -> following fetch address is 0x00000000 (wrap), no redirect when pc wraps to 0.
